// File: rtl/controlador_divisor.sv
// controlador_divisor: 8-bit unsigned restoring divider that produces one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to make a zero divisor skip the iterations and raise DivZero.
module controlador_divisor (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Quociente,
    output logic [7:0] Resto,
    output logic       DivZero
);

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     quociente_q, quociente_d;
    logic [W-1:0]     resto_q, resto_d;

    // One restoring step; the borrow-out of the subtraction is the compare result.
    logic [W-1:0] p_c;
    logic [W:0]   sub_c;
    logic         borrow_c;
    logic [W-1:0] rem_step_c;
    logic [W-1:0] quo_step_c;

    always_comb begin
        p_c        = {rem_q[W-2:0], a_q[cnt_q]};
        sub_c      = {1'b0, p_c} - {1'b0, b_q};
        borrow_c   = sub_c[W];
        rem_step_c = borrow_c ? p_c : sub_c[W-1:0];
        quo_step_c = quo_q;
        quo_step_c[cnt_q] = ~borrow_c;
    end

`ifdef DIV_ZERO_DETECT_EN
    logic divzero_q, divzero_d;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quociente_d = quociente_q;
        resto_d     = resto_q;
`ifdef DIV_ZERO_DETECT_EN
        divzero_d   = divzero_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d   = A;
                    b_d   = B;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = CNT_W'(W - 1);
`ifdef DIV_ZERO_DETECT_EN
                    if (B == '0) begin
                        state_d     = FIM;
                        done_d      = 1'b1;
                        quociente_d = '0;
                        resto_d     = '0;
                        divzero_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = CALC;
                    busy_d  = 1'b1;
`endif
                end
            end

            CALC: begin
                rem_d = rem_step_c;
                quo_d = quo_step_c;
                if (cnt_q == '0) begin
                    // Result registers load only here, so a partial result is never visible.
                    state_d     = FIM;
                    done_d      = 1'b1;
                    quociente_d = quo_step_c;
                    resto_d     = rem_step_c;
`ifdef DIV_ZERO_DETECT_EN
                    divzero_d   = 1'b0;
`endif
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                end
            end

            FIM: begin
                // Start is deliberately ignored during the Done cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quociente_q <= '0;
            resto_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quociente_q <= quociente_d;
            resto_q     <= resto_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= divzero_d;
        end
    end

    assign DivZero = divzero_q;
`else
    assign DivZero = 1'b0;
`endif

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quociente = quociente_q;
    assign Resto     = resto_q;

endmodule

// File: tb/tb_controlador_divisor.sv
// Bench for controlador_divisor: cycle-level reference model plus directed vectors.
// Honours DIV_ZERO_DETECT_EN the same way as the design.
module tb_controlador_divisor;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Busy;
    logic       Done;
    logic [7:0] Quociente;
    logic [7:0] Resto;
    logic       DivZero;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 0;

    controlador_divisor dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Quociente (Quociente),
        .Resto     (Resto),
        .DivZero   (DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: m_t counts cycles since acceptance (0 = idle, 1..8 busy, 9 = done cycle).
    int         m_t  = 0;
    logic [7:0] m_a  = 8'd0;
    logic [7:0] m_b  = 8'd0;
    logic [7:0] m_q  = 8'd0;
    logic [7:0] m_r  = 8'd0;
    logic       m_dz = 1'b0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_t  = 0;
            m_q  = 8'd0;
            m_r  = 8'd0;
            m_dz = 1'b0;
        end else if (m_t == 0) begin
            if (Start) begin
                m_a = A;
                m_b = B;
`ifdef DIV_ZERO_DETECT_EN
                if (B == 8'd0) begin
                    m_t  = 9;
                    m_q  = 8'd0;
                    m_r  = 8'd0;
                    m_dz = 1'b1;
                end else begin
                    m_t = 1;
                end
`else
                m_t = 1;
`endif
            end
        end else if (m_t == 9) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t == 9) begin
                if (m_b == 8'd0) begin
                    m_q = 8'hFF;
                    m_r = m_a;
                end else begin
                    m_q = m_a / m_b;
                    m_r = m_a % m_b;
                end
                m_dz = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("busy",      32'(Busy),      32'((m_t >= 1) && (m_t <= 8)));
            chk("done",      32'(Done),      32'(m_t == 9));
            chk("quociente", 32'(Quociente), 32'(m_q));
            chk("resto",     32'(Resto),     32'(m_r));
            chk("divzero",   32'(DivZero),   32'(m_dz));
            chk("busy_and_done", 32'(Busy & Done), 32'd0);
        end
    end

    task automatic wt(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Called on a negedge while idle; returns in cycle 1 with Start dropped.
    task automatic go(input logic [7:0] a, input logic [7:0] b);
        A = a;
        B = b;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    initial begin
        int nd;
        logic [7:0] vals [11];
        Rst = 1'b1;
        Start = 1'b0;
        A = 8'd0;
        B = 8'd0;
        vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
        wt(2);
        chk_en = 1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_quo",  32'(Quociente), 32'd0);
        Rst = 1'b0;
        wt(1);

        // 100 / 7
        go(8'd100, 8'd7);
        chk("l100_busy_c1", 32'(Busy), 32'd1);
        wt(8);
        chk("l100_done", 32'(Done), 32'd1);
        chk("l100_q", 32'(Quociente), 32'd14);
        chk("l100_r", 32'(Resto), 32'd2);
        chk("l100_dz", 32'(DivZero), 32'd0);
        wt(1);
        chk("l100_idle_done", 32'(Done), 32'd0);

        // Back-to-back with Start held high
        A = 8'd255; B = 8'd1; Start = 1'b1;
        wt(1);
        A = 8'd5; B = 8'd9;
        wt(8);
        chk("b2b1_done", 32'(Done), 32'd1);
        chk("b2b1_q", 32'(Quociente), 32'd255);
        chk("b2b1_r", 32'(Resto), 32'd0);
        wt(1);
        chk("b2b_c10_busy", 32'(Busy), 32'd0);
        chk("b2b_c10_q", 32'(Quociente), 32'd255);
        wt(1);
        chk("b2b_c11_busy", 32'(Busy), 32'd1);
        Start = 1'b0;
        wt(8);
        chk("b2b2_done", 32'(Done), 32'd1);
        chk("b2b2_q", 32'(Quociente), 32'd0);
        chk("b2b2_r", 32'(Resto), 32'd5);
        wt(1);

        // 200 / 0
        go(8'd200, 8'd0);
`ifdef DIV_ZERO_DETECT_EN
        chk("dz_done_c1", 32'(Done), 32'd1);
        chk("dz_busy_c1", 32'(Busy), 32'd0);
        chk("dz_q", 32'(Quociente), 32'd0);
        chk("dz_r", 32'(Resto), 32'd0);
        chk("dz_flag", 32'(DivZero), 32'd1);
        wt(1);
`else
        wt(8);
        chk("z_done", 32'(Done), 32'd1);
        chk("z_q", 32'(Quociente), 32'd255);
        chk("z_r", 32'(Resto), 32'd200);
        chk("z_flag", 32'(DivZero), 32'd0);
        wt(1);
`endif

        // Inputs and Start changing mid-operation are ignored
        go(8'd100, 8'd7);
        wt(2);
        A = 8'd9; B = 8'd3; Start = 1'b1;
        wt(1);
        Start = 1'b0;
        wt(5);
        chk("ign_done", 32'(Done), 32'd1);
        chk("ign_q", 32'(Quociente), 32'd14);
        chk("ign_r", 32'(Resto), 32'd2);
        wt(1);

        // Reset mid-CALC aborts with no Done
        go(8'd100, 8'd7);
        wt(3);
        Rst = 1'b1;
        wt(1);
        Rst = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_q", 32'(Quociente), 32'd0);
        chk("abort_r", 32'(Resto), 32'd0);
        nd = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);

        // Reset wins over Start
        A = 8'd50; B = 8'd5; Start = 1'b1; Rst = 1'b1;
        wt(1);
        chk("rst_prio_busy", 32'(Busy), 32'd0);
        Rst = 1'b0; Start = 1'b0;
        wt(1);

        // Boundary-value grid, then random pairs
        foreach (vals[i]) begin
            foreach (vals[j]) begin
                go(vals[i], vals[j]);
                wt(9);
            end
        end
        repeat (200) begin
            go(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
            wt(9);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
